// File: rtl/i2s_tx_dsp_channel.sv
// ---------------------------------------------------------------------------
// i2s_tx_dsp_channel
//
// DSP-mode (single frame-sync pulse) I2S transmit channel. Words are pulled
// from the TX FIFO into a one-word shadow per channel, moved into the shift
// register at each word boundary and serialized on one or two data lines.
// Transmission is aligned to the external frame sync with a programmable
// bit offset. Everything runs on posedge sck_i.
//
// Ports:
//   sck_i                   bit clock
//   rst_i                   asynchronous active-high reset
//   i2s_ws_i                frame-sync pulse from the external master
//   i2s_ch0_o / i2s_ch1_o   serial data lines
//   fifo_data_i             32-bit TX word, right-justified
//   fifo_data_valid_i       FIFO word available
//   fifo_data_ready_o       block accepts a word this cycle
//   fifo_err_o              one-cycle underrun pulse
//   cfg_en_i                channel enable (0 clears the block)
//   cfg_2ch_i               drive ch1 as well as ch0
//   cfg_num_bits_i          bits per word minus 1 (7/15/23/31)
//   cfg_num_word_i          words per channel minus 1 (non-continuous)
//   cfg_lsb_first_i         1 = LSB first
//   cfg_tx_continuous_i     1 = never stop
//   cfg_slave_dsp_offset_i  sck cycles between ws and the first bit
//
// Build option:
//   I2S_TX_UNDERRUN_REPEAT_EN  when defined, an underrun resends the last
//                              transmitted word instead of zeros.
// ---------------------------------------------------------------------------
module i2s_tx_dsp_channel (
   input  logic        sck_i,
   input  logic        rst_i,
   input  logic        i2s_ws_i,
   output logic        i2s_ch0_o,
   output logic        i2s_ch1_o,
   input  logic [31:0] fifo_data_i,
   input  logic        fifo_data_valid_i,
   output logic        fifo_data_ready_o,
   output logic        fifo_err_o,
   input  logic        cfg_en_i,
   input  logic        cfg_2ch_i,
   input  logic [4:0]  cfg_num_bits_i,
   input  logic [3:0]  cfg_num_word_i,
   input  logic        cfg_lsb_first_i,
   input  logic        cfg_tx_continuous_i,
   input  logic [8:0]  cfg_slave_dsp_offset_i
);

   typedef enum logic [1:0] {IDLE, OFFSET, RUN, DONE} state_t;

   state_t      state_q, state_d;

   logic [31:0] shift0_q, shift1_q;
   logic [31:0] shadow0_q, shadow1_q;
   logic        full0_q, full1_q;
   logic        loaded0_q, loaded1_q;
   logic        tgt_q;
   logic        err_q;
   logic [4:0]  bit_cnt_q;
   logic [3:0]  word_cnt_q;
   logic [8:0]  off_cnt_q;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
   logic [31:0] last0_q, last1_q;
`endif

   logic        sel1;
   logic        tgt_full;
   logic        accept;
   logic        boundary;
   logic        to_done;
   logic        reload;
   logic        pre0, pre1;
   logic        ld0, ld1;
   logic        under0, under1;
   logic [31:0] fill0, fill1;
   logic        bit0, bit1;

   function automatic logic [31:0] shift_step(input logic [31:0] s, input logic lsb);
      return lsb ? {1'b0, s[31:1]} : {s[30:0], 1'b0};
   endfunction

   // FIFO handshake: target shadow alternates ch0/ch1 only in 2-channel mode
   assign sel1              = cfg_2ch_i & tgt_q;
   assign tgt_full          = sel1 ? full1_q : full0_q;
   assign fifo_data_ready_o = cfg_en_i & (state_q != DONE) & ~tgt_full;
   assign accept            = fifo_data_valid_i & fifo_data_ready_o;

   assign boundary = (state_q == RUN) & (bit_cnt_q == cfg_num_bits_i);
   assign to_done  = boundary & (word_cnt_q == cfg_num_word_i) & ~cfg_tx_continuous_i;
   assign reload   = boundary & ~to_done;

   // IDLE preload happens once per shadow so the first bit is already on the line
   assign pre0   = (state_q == IDLE) & full0_q & ~loaded0_q;
   assign pre1   = (state_q == IDLE) & cfg_2ch_i & full1_q & ~loaded1_q;
   assign ld0    = pre0 | (reload & full0_q);
   assign ld1    = pre1 | (reload & cfg_2ch_i & full1_q);
   assign under0 = reload & ~full0_q;
   assign under1 = reload & cfg_2ch_i & ~full1_q;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
   assign fill0 = last0_q;
   assign fill1 = last1_q;
`else
   assign fill0 = '0;
   assign fill1 = '0;
`endif

   assign bit0      = cfg_lsb_first_i ? shift0_q[0] : shift0_q[cfg_num_bits_i];
   assign bit1      = cfg_lsb_first_i ? shift1_q[0] : shift1_q[cfg_num_bits_i];
   assign i2s_ch0_o = (state_q != DONE) & bit0;
   assign i2s_ch1_o = (state_q != DONE) & cfg_2ch_i & bit1;
   assign fifo_err_o = err_q;

   // State register
   always_ff @(posedge sck_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (i2s_ws_i) state_d = (cfg_slave_dsp_offset_i == '0) ? RUN : OFFSET;
         end
         OFFSET: begin
            if (off_cnt_q == cfg_slave_dsp_offset_i) state_d = RUN;
         end
         RUN: begin
            if (to_done) state_d = DONE;
         end
         DONE: state_d = DONE;
         default: state_d = IDLE;
      endcase
      if (!cfg_en_i) state_d = IDLE;
   end

   // Datapath: shadows, shift registers, counters, underrun flag
   always_ff @(posedge sck_i or posedge rst_i) begin
      if (rst_i) begin
         shift0_q   <= '0;
         shift1_q   <= '0;
         shadow0_q  <= '0;
         shadow1_q  <= '0;
         full0_q    <= 1'b0;
         full1_q    <= 1'b0;
         loaded0_q  <= 1'b0;
         loaded1_q  <= 1'b0;
         tgt_q      <= 1'b0;
         err_q      <= 1'b0;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         off_cnt_q  <= '0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
         last0_q    <= '0;
         last1_q    <= '0;
`endif
      end else if (!cfg_en_i) begin
         shift0_q   <= '0;
         shift1_q   <= '0;
         shadow0_q  <= '0;
         shadow1_q  <= '0;
         full0_q    <= 1'b0;
         full1_q    <= 1'b0;
         loaded0_q  <= 1'b0;
         loaded1_q  <= 1'b0;
         tgt_q      <= 1'b0;
         err_q      <= 1'b0;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         off_cnt_q  <= '0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
         last0_q    <= '0;
         last1_q    <= '0;
`endif
      end else begin
         if (accept) begin
            if (sel1) shadow1_q <= fifo_data_i;
            else      shadow0_q <= fifo_data_i;
            tgt_q <= cfg_2ch_i & ~tgt_q;
         end

         // Emptied and refilled in the same cycle leaves the shadow full
         full0_q <= (full0_q & ~ld0) | (accept & ~sel1);
         full1_q <= (full1_q & ~ld1) | (accept & sel1);

         if (pre0) loaded0_q <= 1'b1;
         if (pre1) loaded1_q <= 1'b1;

         if (ld0) begin
            shift0_q <= shadow0_q;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
            last0_q  <= shadow0_q;
`endif
         end else if (under0) begin
            shift0_q <= fill0;
         end else if (state_q == RUN) begin
            shift0_q <= shift_step(shift0_q, cfg_lsb_first_i);
         end

         if (ld1) begin
            shift1_q <= shadow1_q;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
            last1_q  <= shadow1_q;
`endif
         end else if (under1) begin
            shift1_q <= fill1;
         end else if (state_q == RUN) begin
            shift1_q <= shift_step(shift1_q, cfg_lsb_first_i);
         end

         err_q <= under0 | under1;

         if (state_q == IDLE && i2s_ws_i) off_cnt_q <= 9'd1;
         else if (state_q == OFFSET)      off_cnt_q <= off_cnt_q + 9'd1;

         if (state_q == RUN) begin
            if (boundary) begin
               bit_cnt_q  <= '0;
               word_cnt_q <= word_cnt_q + 4'd1;
            end else begin
               bit_cnt_q  <= bit_cnt_q + 5'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx_dsp_channel.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx_dsp_channel
//
// Directed bench for i2s_tx_dsp_channel. A queue stands in for the TX FIFO;
// line data is sampled on the falling edge and assembled into words that are
// compared against hand-computed values.
// Honours I2S_TX_UNDERRUN_REPEAT_EN for the underrun word.
// ---------------------------------------------------------------------------
module tb_i2s_tx_dsp_channel;

   logic        sck_i = 1'b0;
   logic        rst_i;
   logic        i2s_ws_i;
   logic        i2s_ch0_o;
   logic        i2s_ch1_o;
   logic [31:0] fifo_data_i;
   logic        fifo_data_valid_i;
   logic        fifo_data_ready_o;
   logic        fifo_err_o;
   logic        cfg_en_i;
   logic        cfg_2ch_i;
   logic [4:0]  cfg_num_bits_i;
   logic [3:0]  cfg_num_word_i;
   logic        cfg_lsb_first_i;
   logic        cfg_tx_continuous_i;
   logic [8:0]  cfg_slave_dsp_offset_i;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned pops     = 0;
   logic [31:0] fq[$];

   i2s_tx_dsp_channel dut (
      .sck_i                  (sck_i),
      .rst_i                  (rst_i),
      .i2s_ws_i               (i2s_ws_i),
      .i2s_ch0_o              (i2s_ch0_o),
      .i2s_ch1_o              (i2s_ch1_o),
      .fifo_data_i            (fifo_data_i),
      .fifo_data_valid_i      (fifo_data_valid_i),
      .fifo_data_ready_o      (fifo_data_ready_o),
      .fifo_err_o             (fifo_err_o),
      .cfg_en_i               (cfg_en_i),
      .cfg_2ch_i              (cfg_2ch_i),
      .cfg_num_bits_i         (cfg_num_bits_i),
      .cfg_num_word_i         (cfg_num_word_i),
      .cfg_lsb_first_i        (cfg_lsb_first_i),
      .cfg_tx_continuous_i    (cfg_tx_continuous_i),
      .cfg_slave_dsp_offset_i (cfg_slave_dsp_offset_i)
   );

   always #5 sck_i = ~sck_i;

   // FIFO model: pop just after an accepting edge, re-drive on the falling edge
   always @(posedge sck_i) begin
      if (fifo_data_valid_i && fifo_data_ready_o) begin
         #1;
         void'(fq.pop_front());
         pops++;
      end
   end

   always @(negedge sck_i) begin
      fifo_data_valid_i = (fq.size() != 0);
      fifo_data_i       = (fq.size() != 0) ? fq[0] : 32'h0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic setup(input logic [4:0] nbits, input logic two_ch, input logic lsb,
                        input logic cont, input logic [3:0] nword, input logic [8:0] off);
      @(negedge sck_i);
      cfg_en_i = 1'b0;
      i2s_ws_i = 1'b0;
      fq.delete();
      repeat (2) @(negedge sck_i);
      pops                   = 0;
      cfg_num_bits_i         = nbits;
      cfg_2ch_i              = two_ch;
      cfg_lsb_first_i        = lsb;
      cfg_tx_continuous_i    = cont;
      cfg_num_word_i         = nword;
      cfg_slave_dsp_offset_i = off;
   endtask

   task automatic enable_and_settle();
      cfg_en_i = 1'b1;
      repeat (5) @(negedge sck_i);
   endtask

   // ws is sampled on the edge between the two falling edges; the caller
   // takes sample 0 right after this returns
   task automatic fire_ws();
      i2s_ws_i = 1'b1;
      @(negedge sck_i);
      i2s_ws_i = 1'b0;
   endtask

   logic [31:0] v0, v1;
   logic [31:0] w [3];
   int unsigned err_cnt, err_at;

   initial begin
      rst_i                  = 1'b1;
      i2s_ws_i               = 1'b0;
      cfg_en_i               = 1'b0;
      cfg_2ch_i              = 1'b0;
      cfg_num_bits_i         = 5'd15;
      cfg_num_word_i         = 4'd0;
      cfg_lsb_first_i        = 1'b0;
      cfg_tx_continuous_i    = 1'b1;
      cfg_slave_dsp_offset_i = 9'd0;
      fifo_data_i            = 32'h0;
      fifo_data_valid_i      = 1'b0;

      // Reset state
      repeat (2) @(negedge sck_i);
      check("rst_ch0",   {31'h0, i2s_ch0_o},         32'h0);
      check("rst_ch1",   {31'h0, i2s_ch1_o},         32'h0);
      check("rst_ready", {31'h0, fifo_data_ready_o}, 32'h0);
      check("rst_err",   {31'h0, fifo_err_o},        32'h0);
      rst_i = 1'b0;

      // 1: MSB-first 16-bit single channel, offset 0
      setup(5'd15, 1'b0, 1'b0, 1'b1, 4'd0, 9'd0);
      fq.push_back(32'h0000A5C3);
      enable_and_settle();
      check("t1_pops",    pops,                       32'd1);
      check("t1_ready",   {31'h0, fifo_data_ready_o}, 32'h1);
      check("t1_preload", {31'h0, i2s_ch0_o},         32'h1);
      fire_ws();
      v0 = '0; v1 = '0;
      for (int i = 0; i < 16; i++) begin
         if (i != 0) @(negedge sck_i);
         v0 = {v0[30:0], i2s_ch0_o};
         v1 = v1 | {31'h0, i2s_ch1_o};
      end
      check("t1_word",    v0, 32'h0000A5C3);
      check("t1_ch1_off", v1, 32'h0);

      // 2: LSB-first 8-bit, two channels
      setup(5'd7, 1'b1, 1'b1, 1'b1, 4'd0, 9'd0);
      fq.push_back(32'h81);
      fq.push_back(32'h3C);
      enable_and_settle();
      fire_ws();
      v0 = '0; v1 = '0;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) @(negedge sck_i);
         v0[i] = i2s_ch0_o;
         v1[i] = i2s_ch1_o;
      end
      check("t2_ch0", v0, 32'h81);
      check("t2_ch1", v1, 32'h3C);

      // 3: offset 5 -> first bit held for 5 OFFSET cycles plus the RUN entry
      //    cycle; stray ws in RUN ignored
      setup(5'd7, 1'b0, 1'b0, 1'b1, 4'd0, 9'd5);
      fq.push_back(32'hB2);
      enable_and_settle();
      fire_ws();
      v0 = '0;
      for (int i = 0; i < 13; i++) begin
         if (i != 0) @(negedge sck_i);
         v0 = {v0[30:0], i2s_ch0_o};
         if (i == 8) i2s_ws_i = 1'b1;
         if (i == 9) i2s_ws_i = 1'b0;
      end
      check("t3_offset_seq", v0, 32'h1FB2);

      // 4: non-continuous, 3 words of 32 bits, then DONE
      setup(5'd31, 1'b0, 1'b0, 1'b0, 4'd2, 9'd0);
      fq.push_back(32'hDEADBEEF);
      fq.push_back(32'h0F0F1234);
      fq.push_back(32'hC001D00D);
      fq.push_back(32'h11111111);
      fq.push_back(32'h22222222);
      enable_and_settle();
      fire_ws();
      w[0] = '0; w[1] = '0; w[2] = '0;
      for (int i = 0; i < 96; i++) begin
         if (i != 0) @(negedge sck_i);
         w[i / 32] = {w[i / 32][30:0], i2s_ch0_o};
      end
      check("t4_word0", w[0], 32'hDEADBEEF);
      check("t4_word1", w[1], 32'h0F0F1234);
      check("t4_word2", w[2], 32'hC001D00D);
      @(negedge sck_i);
      check("t4_done_line",  {31'h0, i2s_ch0_o},         32'h0);
      check("t4_done_ready", {31'h0, fifo_data_ready_o}, 32'h0);
      repeat (3) @(negedge sck_i);
      check("t4_done_hold",  {30'h0, i2s_ch0_o, fifo_data_ready_o}, 32'h0);

      // 5: underrun after word 0, continuous
      setup(5'd7, 1'b0, 1'b0, 1'b1, 4'd0, 9'd0);
      fq.push_back(32'h96);
      enable_and_settle();
      fire_ws();
      v0 = '0; err_cnt = 0; err_at = 0;
      for (int i = 0; i < 16; i++) begin
         if (i != 0) @(negedge sck_i);
         v0 = {v0[30:0], i2s_ch0_o};
         if (fifo_err_o) begin
            err_cnt++;
            err_at = i;
         end
      end
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
      check("t5_underrun_word", v0, 32'h9696);
`else
      check("t5_underrun_word", v0, 32'h9600);
`endif
      check("t5_err_count", err_cnt, 32'd1);
      check("t5_err_cycle", err_at,  32'd8);

      // 6: enable dropped mid-word, then clean restart from the next FIFO word
      setup(5'd15, 1'b0, 1'b0, 1'b1, 4'd0, 9'd0);
      fq.push_back(32'h1234);
      fq.push_back(32'hABCD);
      fq.push_back(32'h5A0F);
      enable_and_settle();
      fire_ws();
      repeat (5) @(negedge sck_i);
      cfg_en_i = 1'b0;
      #1;
      check("t6_ready_comb", {31'h0, fifo_data_ready_o}, 32'h0);
      @(negedge sck_i);
      check("t6_line",  {31'h0, i2s_ch0_o},         32'h0);
      check("t6_ready", {31'h0, fifo_data_ready_o}, 32'h0);
      check("t6_fifo_kept", fq.size(), 32'd1);
      enable_and_settle();
      fire_ws();
      v0 = '0;
      for (int i = 0; i < 16; i++) begin
         if (i != 0) @(negedge sck_i);
         v0 = {v0[30:0], i2s_ch0_o};
      end
      check("t6_restart_word", v0, 32'h5A0F);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
